// File: rtl/pipe_scoreboard_pkg.sv
// Shared constants for the pipeline scoreboard: default geometry,
// forward-select encoding and the standard result latencies.
// Imported by the interface, the entry sub-module user and the bench.
package pipe_scoreboard_pkg;

  // Forward-select value meaning "read the register file"
  localparam int FWD_SEL_REGFILE = 0;

  // Stages until a result becomes forwardable
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Default geometry
  localparam int PIPE_DEPTH_DEF   = 3;
  localparam int REG_ADDR_LEN_DEF = 4;
  localparam int NUM_SRC_DEF      = 2;
  localparam int CNT_W_DEF        = 2;
  localparam int FSEL_W_DEF       = 2;
  localparam int STALL_CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Issue-side bundle between the ID stage and the scoreboard.
// The master drives the issuing instruction; the slave returns stall,
// forward selects and the stall counter.
interface pipe_scoreboard_if
  import pipe_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FSEL_W       = FSEL_W_DEF,
  parameter int STALL_CNT_W  = STALL_CNT_W_DEF
);
  logic                            forward_en;
  logic                            issue_valid;
  logic                            issue_wb_en;
  logic [REG_ADDR_LEN-1:0]         issue_dest;
  logic [CNT_W-1:0]                issue_lat;
  logic [NUM_SRC*REG_ADDR_LEN-1:0] src_addr;
  logic [NUM_SRC-1:0]              src_used;
  logic                            flush;
  logic                            stall;
  logic [NUM_SRC*FSEL_W-1:0]       fwd_sel;
  logic [STALL_CNT_W-1:0]          stall_cycles;

  modport master (
    output forward_en, issue_valid, issue_wb_en, issue_dest, issue_lat,
           src_addr, src_used, flush,
    input  stall, fwd_sel, stall_cycles
  );

  modport slave (
    input  forward_en, issue_valid, issue_wb_en, issue_dest, issue_lat,
           src_addr, src_used, flush,
    output stall, fwd_sel, stall_cycles
  );
endinterface

// File: rtl/pipe_scoreboard_entry.sv
// One scoreboard entry: cycles-to-writeback and cycles-to-forwardable
// countdown timers, both saturating at zero; a load overrides the countdown.
// busy = producer not yet in WB; pend = result not yet forwardable.
module scoreboard_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] wb_init_i,
  input  logic [CNT_W-1:0] rdy_init_i,
  output logic [CNT_W-1:0] wb_cnt_o,
  output logic             busy_o,
  output logic             pend_o
);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0] rdy_cnt_q, rdy_cnt_d;

  // Next state: a fresh writer reloads both timers, otherwise count down to 0
  always_comb begin
    wb_cnt_d  = (wb_cnt_q  != '0) ? wb_cnt_q  - ONE_C : '0;
    rdy_cnt_d = (rdy_cnt_q != '0) ? rdy_cnt_q - ONE_C : '0;
    if (load_i) begin
      wb_cnt_d  = wb_init_i;
      rdy_cnt_d = rdy_init_i;
    end
  end

  // Timer registers; reset drops any pending write immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt_q  <= '0;
      rdy_cnt_q <= '0;
    end else begin
      wb_cnt_q  <= wb_cnt_d;
      rdy_cnt_q <= rdy_cnt_d;
    end
  end

  // The regfile is write-first, so a producer sitting in WB (count 1) is already visible
  assign busy_o   = wb_cnt_q  > ONE_C;
  assign pend_o   = rdy_cnt_q > ONE_C;
  assign wb_cnt_o = wb_cnt_q;
endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding controller: per-register countdown scoreboard checked by every source in ID.
// Latency: stall and fwd_sel are combinational from scoreboard state and ID inputs; entries update on the edge.
// Backpressure: stall holds IF/ID and blocks the accept; flush suppresses both stall and accept.
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FSEL_W       = FSEL_W_DEF,
  parameter int STALL_CNT_W  = STALL_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pipe_scoreboard_if.slave sb
);
  localparam int NREG = 1 << REG_ADDR_LEN;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PIPE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]       wb_cnt [NREG];
  logic [NREG-1:0]        busy;
  logic [NREG-1:0]        pend;
  logic [CNT_W-1:0]       lat_eff;
  logic [NUM_SRC-1:0]     hz;
  logic [NUM_SRC-1:0]     src_stall;
  logic                   stall_w;
  logic                   accept;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Out-of-range latencies: 0 behaves as an ALU op, anything past WB is capped at WB
  always_comb begin
    lat_eff = sb.issue_lat;
    if (sb.issue_lat == '0) begin
      lat_eff = ONE_C;
    end else if (sb.issue_lat > DEPTH_C) begin
      lat_eff = DEPTH_C;
    end
  end

  assign stall_w = sb.issue_valid && !sb.flush && (|src_stall);
  assign accept  = sb.issue_valid && sb.issue_wb_en && !stall_w && !sb.flush
                   && (sb.issue_dest != '0);

  // r0 is hard-wired: never tracked, never busy
  assign wb_cnt[0] = '0;
  assign busy[0]   = 1'b0;
  assign pend[0]   = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    scoreboard_entry #(.CNT_W(CNT_W)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept && (sb.issue_dest == REG_ADDR_LEN'(r))),
      .wb_init_i  (DEPTH_C),
      .rdy_init_i (lat_eff),
      .wb_cnt_o   (wb_cnt[r]),
      .busy_o     (busy[r]),
      .pend_o     (pend[r])
    );
  end

  // Per-source hazard: without forwarding wait for writeback, with it only until forwardable.
  // wb_cnt-1 is the producer's distance from WB once the consumer reaches EXE.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_LEN-1:0] src;
    assign src          = sb.src_addr[i*REG_ADDR_LEN +: REG_ADDR_LEN];
    assign hz[i]        = sb.src_used[i] && (src != '0) && busy[src];
    assign src_stall[i] = hz[i] && (!sb.forward_en || pend[src]);
    assign sb.fwd_sel[i*FSEL_W +: FSEL_W] = (sb.forward_en && hz[i])
                                            ? FSEL_W'(wb_cnt[src] - ONE_C)
                                            : FSEL_W'(FWD_SEL_REGFILE);
  end

  // Stall performance counter, sticks at all-ones
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_w && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb.stall        = stall_w;
  assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed scenarios plus randomized traffic
// against a timestamp-based reference (absolute writeback/ready times per register).
module tb_pipe_scoreboard;
  import pipe_scoreboard_pkg::*;

  localparam int DEPTH = PIPE_DEPTH_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_scoreboard_if ifc ();
  pipe_scoreboard dut (.clk(clk), .rst(rst), .sb(ifc));

  int checks   = 0;
  int failures = 0;

  // Reference: absolute cycle at which writeback count / ready count reach 0
  int now = 0;
  int wb_t  [16];
  int rdy_t [16];
  int m_stalls = 0;

  function automatic int left(int t);
    return (t > now) ? t - now : 0;
  endfunction

  function automatic int src_of(int i);
    return (i == 0) ? int'(ifc.src_addr[3:0]) : int'(ifc.src_addr[7:4]);
  endfunction

  function automatic bit m_hz(int i);
    int s;
    s = src_of(i);
    return ifc.src_used[i] && (s != 0) && (left(wb_t[s]) >= 2);
  endfunction

  function automatic bit m_stall();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_hz(i) && (!ifc.forward_en || left(rdy_t[src_of(i)]) >= 2)) any = 1'b1;
    return ifc.issue_valid && !ifc.flush && any;
  endfunction

  function automatic int m_fwd(int i);
    return (ifc.forward_en && m_hz(i)) ? left(wb_t[src_of(i)]) - 1 : 0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 16; r++) begin
      wb_t[r]  = 0;
      rdy_t[r] = 0;
    end
    m_stalls = 0;
  endtask

  task automatic drive(bit v, bit we, int dest, int lat, int s0, int s1, bit [1:0] used, bit fl);
    ifc.issue_valid = v;
    ifc.issue_wb_en = we;
    ifc.issue_dest  = 4'(dest);
    ifc.issue_lat   = 2'(lat);
    ifc.src_addr    = {4'(s1), 4'(s0)};
    ifc.src_used    = used;
    ifc.flush       = fl;
  endtask

  // Advance one clock edge and move the reference along with it
  task automatic tick();
    bit st, acc;
    int lat, d;
    st  = m_stall();
    d   = int'(ifc.issue_dest);
    acc = ifc.issue_valid && ifc.issue_wb_en && !st && !ifc.flush && (d != 0);
    lat = int'(ifc.issue_lat);
    if (lat == 0) lat = 1;
    if (lat > DEPTH) lat = DEPTH;
    @(posedge clk);
    now++;
    if (rst) begin
      m_clear();
    end else begin
      if (st && m_stalls < 65535) m_stalls++;
      if (acc) begin
        wb_t[d]  = now + DEPTH;
        rdy_t[d] = now + lat;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_clear();
    drive(0, 0, 0, 1, 0, 0, 2'b00, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_clear();
    for (int k = 0; k < 3; k++) begin
      ifc.forward_en = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
            $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++;
      if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0 || ifc.stall_cycles !== 16'd0) begin
        failures++;
        $display("FAIL reset[%0d] stall=%0b fwd_sel=%0d stall_cycles=%0d expected all 0",
                 k, ifc.stall, ifc.fwd_sel, ifc.stall_cycles);
      end
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 1, 3, 5, 2'b11, 0);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0 || ifc.stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_release stall=%0b fwd_sel=%0d stall_cycles=%0d expected all 0",
               ifc.stall, ifc.fwd_sel, ifc.stall_cycles);
    end
    tick();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    ifc.forward_en = 1'b1;
    drive(1, 1, 3, LAT_ALU, 0, 0, 2'b00, 0);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0) begin
      failures++;
      $display("FAIL alu_issue stall=%0b expected 0", ifc.stall);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 3, 0, 2'b01, 0);
      @(negedge clk);
      checks++;
      if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'(2 - k)) begin
        failures++;
        $display("FAIL alu_fwd[%0d] stall=%0b fwd_sel=%0d expected stall=0 fwd_sel=%0d",
                 k, ifc.stall, ifc.fwd_sel, 2 - k);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ifc.forward_en = 1'b1;
    drive(1, 1, 5, LAT_LOAD, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 1, 0, 5, 2'b10, 0);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall stall=%0b expected 1", ifc.stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'b0100) begin
      failures++;
      $display("FAIL load_use_fwd stall=%0b fwd_sel=%0d expected stall=0 fwd_sel=4",
               ifc.stall, ifc.fwd_sel);
    end
    checks++;
    if (ifc.stall_cycles !== 16'd1) begin
      failures++;
      $display("FAIL load_use_count stall_cycles=%0d expected 1", ifc.stall_cycles);
    end
    tick();
  endtask

  task automatic test_no_forward();
    do_reset();
    ifc.forward_en = 1'b0;
    drive(1, 1, 3, LAT_ALU, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 1, 3, 0, 2'b01, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (ifc.stall !== 1'b1 || ifc.fwd_sel !== 4'd0) begin
        failures++;
        $display("FAIL nofwd_stall[%0d] stall=%0b fwd_sel=%0d expected stall=1 fwd_sel=0",
                 k, ifc.stall, ifc.fwd_sel);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0 || ifc.stall_cycles !== 16'd2) begin
      failures++;
      $display("FAIL nofwd_release stall=%0b fwd_sel=%0d stall_cycles=%0d expected 0 0 2",
               ifc.stall, ifc.fwd_sel, ifc.stall_cycles);
    end
    tick();
  endtask

  task automatic test_r0_flush();
    do_reset();
    ifc.forward_en = 1'b1;
    drive(1, 1, 0, LAT_LOAD, 0, 0, 2'b00, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 1, 0, 0, 2'b11, 0);
      @(negedge clk);
      checks++;
      if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0) begin
        failures++;
        $display("FAIL r0[%0d] stall=%0b fwd_sel=%0d expected 0 0", k, ifc.stall, ifc.fwd_sel);
      end
      tick();
    end
    drive(1, 1, 6, LAT_LOAD, 0, 0, 2'b00, 1);
    tick();
    drive(1, 0, 0, 1, 6, 6, 2'b11, 0);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0) begin
      failures++;
      $display("FAIL flush_accept stall=%0b fwd_sel=%0d expected 0 0", ifc.stall, ifc.fwd_sel);
    end
    tick();
    drive(1, 1, 5, LAT_LOAD, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 1, 5, 0, 2'b01, 1);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall stall=%0b expected 0", ifc.stall);
    end
    tick();
  endtask

  task automatic test_youngest_and_mid_reset();
    do_reset();
    ifc.forward_en = 1'b1;
    drive(1, 1, 4, LAT_LOAD, 0, 0, 2'b00, 0);
    tick();
    drive(1, 1, 4, LAT_ALU, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 1, 4, 0, 2'b01, 0);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd2) begin
      failures++;
      $display("FAIL youngest stall=%0b fwd_sel=%0d expected stall=0 fwd_sel=2",
               ifc.stall, ifc.fwd_sel);
    end
    tick();
    drive(1, 1, 4, LAT_LOAD, 0, 0, 2'b00, 0);
    tick();
    drive(1, 0, 0, 1, 4, 0, 2'b01, 0);
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst_pre stall=%0b expected 1", ifc.stall);
    end
    rst = 1'b1;
    m_clear();
    #1;
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0 || ifc.stall_cycles !== 16'd0) begin
      failures++;
      $display("FAIL mid_rst_async stall=%0b fwd_sel=%0d stall_cycles=%0d expected all 0",
               ifc.stall, ifc.fwd_sel, ifc.stall_cycles);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.fwd_sel !== 4'd0) begin
      failures++;
      $display("FAIL mid_rst_after stall=%0b fwd_sel=%0d expected 0 0", ifc.stall, ifc.fwd_sel);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] ef;
    do_reset();
    ifc.forward_en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) ifc.forward_en = ~ifc.forward_en;
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      @(negedge clk);
      ef = {2'(m_fwd(1)), 2'(m_fwd(0))};
      checks++;
      if (ifc.stall !== m_stall()) begin
        failures++;
        $display("FAIL rand_stall[%0d] got=%0b exp=%0b", k, ifc.stall, m_stall());
      end
      checks++;
      if (ifc.fwd_sel !== ef) begin
        failures++;
        $display("FAIL rand_fwd[%0d] got=%0h exp=%0h", k, ifc.fwd_sel, ef);
      end
      checks++;
      if (ifc.stall_cycles !== 16'(m_stalls)) begin
        failures++;
        $display("FAIL rand_count[%0d] got=%0d exp=%0d", k, ifc.stall_cycles, m_stalls);
      end
      tick();
    end
  endtask

  initial begin
    m_clear();
    ifc.forward_en = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 2'b00, 0);
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_no_forward();
    test_r0_flush();
    test_youngest_and_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
